// File: rtl/spi_aes_frame_driver.sv
// Host-side SPI frame driver for the serial AES-decrypt slave: shifts {key,cipher} out, waits, captures plaintext.
// Optional build macro SPI_AES_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module spi_aes_frame_driver #(
    parameter int N           = 128,
    parameter int WAIT_CYCLES = 21
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   key,
    input  logic [127:0]   cipher,
    output logic           busy,
    output logic           done,
    output logic [127:0]   plain_out,
    output logic           spi_in,
    output logic           spi_chip,
    output logic           spi_en,
    output logic           spi_rst,
    input  logic           spi_out
`ifdef SPI_AES_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    localparam int SHIFT_LEN = 129 + N;
    localparam int BIT_W     = $clog2(SHIFT_LEN);
    localparam int WAIT_W    = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        CAPT,
        FIN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [127+N:0]      shift_reg;
    logic [127:0]        cap_reg;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          cap_cnt;
    logic                link_active;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (bit_cnt == BIT_W'(SHIFT_LEN - 1)) state_d = WAIT;
            WAIT:    if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) state_d = CAPT;
            CAPT:    if (cap_cnt == 8'd127) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        link_active = (state_d == SHIFT) || (state_d == WAIT) || (state_d == CAPT);
    end

    // SPI pins and status flags are registered from the next state, so they line up with the state cycle they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_reg <= '0;
            cap_reg   <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            cap_cnt   <= '0;
            plain_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_in    <= 1'b0;
            spi_chip  <= 1'b1;
            spi_en    <= 1'b0;
            spi_rst   <= 1'b1;
        end else begin
            state_q  <= state_d;
            busy     <= link_active;
            spi_chip <= !link_active;
            spi_en   <= link_active;
            done     <= (state_d == FIN);
            spi_rst  <= (state_d == FIN);
            spi_in   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_reg <= {key, cipher};
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // The first SHIFT cycle carries the discarded preamble; each later cycle carries one data bit.
                    if (bit_cnt != BIT_W'(SHIFT_LEN - 1)) begin
                        spi_in    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) cap_cnt <= '0;
                end
                CAPT: begin
                    cap_reg[cap_cnt[6:0]] <= spi_out;
                    cap_cnt               <= cap_cnt + 1'b1;
                    if (cap_cnt == 8'd127) plain_out <= {spi_out, cap_reg[126:0]};
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPI_AES_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state_q == FIN) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
